// File: rtl/jesd204_up_sysref_align_seq_if.sv
// Register-bank write port shared with the SYSREF block,
// plus the bank's writeable flag and sticky SYSREF status.
interface jesd204_up_sysref_align_seq_if;
  logic        up_wreq;
  logic [11:0] up_waddr;
  logic [31:0] up_wdata;
  logic        up_cfg_is_writeable;
  logic [1:0]  up_sysref_status;

  modport master (
    output up_wreq, up_waddr, up_wdata,
    input  up_cfg_is_writeable, up_sysref_status
  );

  modport slave (
    input  up_wreq, up_waddr, up_wdata,
    output up_cfg_is_writeable, up_sysref_status
  );
endinterface

// File: rtl/jesd204_up_sysref_align_seq.sv
// SYSREF alignment sequencer: programs offset/mode, clears
// sticky status, waits for an edge and retries on error.
module jesd204_up_sysref_align_seq #(
  parameter int MAX_RETRIES   = 3,
  parameter int TIMEOUT_WIDTH = 20
) (
  input  logic       up_clk,
  input  logic       up_reset,
  input  logic       up_seq_start,
  input  logic       up_seq_abort,
  input  logic [7:0] up_seq_lmfc_offset,
  input  logic       up_seq_oneshot,
  jesd204_up_sysref_align_seq_if.master bus,
  output logic       up_seq_busy,
  output logic       up_seq_done,
  output logic       up_seq_fail,
  output logic [1:0] up_seq_fail_cause,
  output logic [3:0] up_seq_attempts
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_OFFSET, S_WR_MODE, S_CLEAR, S_SETTLE,
    S_WAIT_EDGE, S_RETRY, S_DONE, S_FAIL
  } state_t;

  localparam logic [4:0] MAXR = 5'(MAX_RETRIES);
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE =
    {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

  state_t state, state_n;
  logic [7:0] offset;
  logic       oneshot;
  logic [TIMEOUT_WIDTH-1:0] cnt, cnt_inc;
  logic        wr_n, start_ok, att_inc;
  logic [11:0] addr_n;
  logic [31:0] data_n;
  logic [1:0]  cause_n;
  logic        busy_n;

  assign cnt_inc = cnt + CNT_ONE;

  always_comb begin
    state_n  = state;
    wr_n     = 1'b0;
    addr_n   = bus.up_waddr;
    data_n   = bus.up_wdata;
    cause_n  = up_seq_fail_cause;
    start_ok = 1'b0;
    att_inc  = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (up_seq_start) begin
          start_ok = 1'b1;
          cause_n  = 2'b00;
          state_n  = S_WR_OFFSET;
        end
      end
      S_WR_OFFSET: begin
        if (bus.up_cfg_is_writeable) begin
          wr_n    = 1'b1;
          addr_n  = 12'h041;
          data_n  = {22'h0, offset, 2'b00};
          state_n = S_WR_MODE;
        end
      end
      S_WR_MODE: begin
        if (bus.up_cfg_is_writeable) begin
          wr_n    = 1'b1;
          addr_n  = 12'h040;
          data_n  = {30'h0, oneshot, 1'b0};
          state_n = S_CLEAR;
        end
      end
      S_CLEAR: begin
        wr_n    = 1'b1;
        addr_n  = 12'h042;
        data_n  = 32'h3;
        att_inc = 1'b1;
        state_n = S_SETTLE;
      end
      S_SETTLE: state_n = S_WAIT_EDGE;
      S_WAIT_EDGE: begin
        // error beats edge when both are seen together
        if (bus.up_sysref_status[1]) begin
          state_n = S_RETRY;
        end else if (bus.up_sysref_status[0]) begin
          state_n = S_DONE;
        end else if (&cnt_inc) begin
          state_n = S_FAIL;
          cause_n = 2'b01;
        end
      end
      S_RETRY: begin
        if ({1'b0, up_seq_attempts} <= MAXR) begin
          state_n = S_CLEAR;
        end else begin
          state_n = S_FAIL;
          cause_n = 2'b10;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // abort drops the sequence but lets this cycle's write out
    if (up_seq_abort) begin
      state_n  = S_IDLE;
      start_ok = 1'b0;
      cause_n  = up_seq_fail_cause;
    end
  end

  assign busy_n = !(state_n inside {S_IDLE, S_DONE, S_FAIL});

  always_ff @(posedge up_clk) begin
    if (up_reset) begin
      state             <= S_IDLE;
      offset            <= '0;
      oneshot           <= 1'b0;
      cnt               <= '0;
      bus.up_wreq       <= 1'b0;
      bus.up_waddr      <= '0;
      bus.up_wdata      <= '0;
      up_seq_busy       <= 1'b0;
      up_seq_done       <= 1'b0;
      up_seq_fail       <= 1'b0;
      up_seq_fail_cause <= '0;
      up_seq_attempts   <= '0;
    end else begin
      state       <= state_n;
      bus.up_wreq <= wr_n;
      if (wr_n) begin
        bus.up_waddr <= addr_n;
        bus.up_wdata <= data_n;
      end
      if (start_ok) begin
        offset          <= up_seq_lmfc_offset;
        oneshot         <= up_seq_oneshot;
        up_seq_attempts <= '0;
      end else if (att_inc && up_seq_attempts != 4'hf) begin
        up_seq_attempts <= up_seq_attempts + 4'd1;
      end
      if (att_inc) begin
        cnt <= '0;
      end else if (state == S_WAIT_EDGE) begin
        cnt <= cnt_inc;
      end
      up_seq_fail_cause <= cause_n;
      up_seq_busy       <= busy_n;
      up_seq_done       <= (state_n == S_DONE);
      up_seq_fail       <= (state_n == S_FAIL);
    end
  end

endmodule
